// File: rtl/poly_mem_pkg.sv
// Shared definitions for the polynomial memory clients.
//   KYBER_Q        : ML-KEM modulus
//   unpack_state_t : unpack writer FSM states
//   bank_w()       : bank-select width for a given bank count (minimum 1 bit)
package poly_mem_pkg;

    localparam int KYBER_Q = 3329;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } unpack_state_t;

    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/poly_unpack_writer_if.sv
// Pack/Unpack write port of the polynomial memory.
//   pu_req   : write request (master -> memory)
//   pu_bank  : target bank
//   pu_we    : write enable, mirrors pu_req for a write-only client
//   pu_addr  : coefficient index
//   pu_wdata : coefficient, zero-extended to the word width
//   pu_stall : same-cycle reject from the memory arbiter (memory -> master)
interface poly_unpack_writer_if #(
    parameter int BANK_W = 2,
    parameter int ADDR_W = 8,
    parameter int W      = 16
);

    logic              pu_req;
    logic [BANK_W-1:0] pu_bank;
    logic              pu_we;
    logic [ADDR_W-1:0] pu_addr;
    logic [W-1:0]      pu_wdata;
    logic              pu_stall;

    modport master (
        output pu_req, pu_bank, pu_we, pu_addr, pu_wdata,
        input  pu_stall
    );

    modport slave (
        input  pu_req, pu_bank, pu_we, pu_addr, pu_wdata,
        output pu_stall
    );

endinterface

// File: rtl/poly_unpack_writer_byte_bit_accum.sv
// LSB-first bit accumulator for ByteDecode.
//   clr_i           : clear accumulator and bit count
//   push_i          : append push_data_i above the bits already held
//   pop_i           : drop the lowest D bits
//   raw_next_o      : lowest D bits of the accumulator after this cycle's update
//   has_coef_next_o : bit count after this cycle's update is >= D
// Only one of clr/push/pop acts per cycle, in that priority order. The
// look-ahead outputs let the owner register the next coefficient on the same
// edge that makes it available.
module byte_bit_accum #(
    parameter int D     = 12,
    parameter int ACC_W = D + 7,
    parameter int CNT_W = $clog2(D + 8)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [7:0]   push_data_i,
    input  logic         pop_i,
    output logic [D-1:0] raw_next_o,
    output logic         has_coef_next_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            // Pushes only happen while cnt < D, so the shifted byte fits.
            acc_d = acc_q | (ACC_W'(push_data_i) << cnt_q);
            cnt_d = cnt_q + CNT_W'(8);
        end else if (pop_i) begin
            acc_d = acc_q >> D;
            cnt_d = cnt_q - CNT_W'(D);
        end
    end

    assign raw_next_o      = acc_d[D-1:0];
    assign has_coef_next_o = (cnt_d >= CNT_W'(D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/poly_unpack_writer.sv
// ByteDecode_D unpacker feeding the polynomial memory write port.
//   start/bank_sel     : begin a run into the selected bank (IDLE only)
//   abort              : abandon the current run
//   in_valid/in_data   : encoded byte stream, accepted when in_ready is high
//   pu                 : memory write port (master side)
//   busy/done          : run in progress / one-cycle completion pulse
//   range_err          : sticky, a raw 12-bit coefficient was >= Q
// All pu_* outputs come straight from registers; the coefficient presented
// next is computed from the accumulator look-ahead and loaded on the edge
// that enters (or stays in) WRITE. pu_stall only steers the next state.
module poly_unpack_writer
    import poly_mem_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int N         = 256,
    parameter int W         = 16,
    parameter int ADDR_W    = $clog2(N),
    parameter int D         = 12,
    parameter int Q         = KYBER_Q
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [bank_w(NUM_BANKS)-1:0]  bank_sel,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    poly_unpack_writer_if.master          pu,
    output logic                          busy,
    output logic                          done,
    output logic                          range_err
);

    localparam int BANK_W = bank_w(NUM_BANKS);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FILL  = FILL;
    localparam logic [1:0] S_WRITE = WRITE;

    if (D < 1 || D > 12 || ((N * D) % 8) != 0) begin : g_param_err
        $error("poly_unpack_writer: D must be 1..12 and N*D a multiple of 8");
    end

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              range_err_q, range_err_d;
    logic              req_q, req_d;
    logic [W-1:0]      wdata_q, wdata_d;
    logic              ge_q_q, ge_q_d;    // presented coefficient was reduced

    logic              clr, push, pop, accept;
    logic [D-1:0]      raw_next;
    logic              has_coef_next;
    logic [W-1:0]      raw_w, coef_next;
    logic              raw_ge_q;

    byte_bit_accum #(.D(D)) u_accum (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_i           (clr),
        .push_i          (push),
        .push_data_i     (in_data),
        .pop_i           (pop),
        .raw_next_o      (raw_next),
        .has_coef_next_o (has_coef_next)
    );

    assign raw_w = W'(raw_next);

    // raw <= 4095 < 2Q, so one conditional subtract fully reduces.
    if (D == 12) begin : g_reduce
        assign raw_ge_q  = (raw_w >= W'(Q));
        assign coef_next = raw_ge_q ? (raw_w - W'(Q)) : raw_w;
    end else begin : g_no_reduce
        assign raw_ge_q  = 1'b0;
        assign coef_next = raw_w;
    end

    assign in_ready = (state_q == S_FILL);
    assign push     = in_valid && in_ready;
    assign accept   = req_q && !pu.pu_stall;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        range_err_d = range_err_q;
        req_d       = req_q;
        wdata_d     = wdata_q;
        ge_q_d      = ge_q_q;
        clr         = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_FILL;
                    bank_d      = bank_sel;
                    addr_d      = '0;
                    clr         = 1'b1;
                    range_err_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (push && has_coef_next) begin
                    state_d = S_WRITE;
                    req_d   = 1'b1;
                    wdata_d = coef_next;
                    ge_q_d  = raw_ge_q;
                end
            end

            S_WRITE: begin
                // An unstalled write lands even in the abort cycle, so its
                // side effects are committed regardless of abort.
                if (accept) begin
                    pop = 1'b1;
                    if (ge_q_q) begin
                        range_err_d = 1'b1;
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    req_d   = 1'b0;
                end else if (accept) begin
                    if (addr_q == ADDR_W'(N - 1)) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (has_coef_next) begin
                            // Enough bits left for another coefficient
                            // without fetching a byte.
                            wdata_d = coef_next;
                            ge_q_d  = raw_ge_q;
                        end else begin
                            state_d = S_FILL;
                            req_d   = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            bank_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            req_q       <= 1'b0;
            wdata_q     <= '0;
            ge_q_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
            req_q       <= req_d;
            wdata_q     <= wdata_d;
            ge_q_q      <= ge_q_d;
        end
    end

    assign pu.pu_req   = req_q;
    assign pu.pu_we    = req_q;
    assign pu.pu_bank  = bank_q;
    assign pu.pu_addr  = addr_q;
    assign pu.pu_wdata = wdata_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_poly_unpack_writer.sv
module tb_poly_unpack_writer;

    localparam int NCOEF  = 256;
    localparam int NB12   = 384;
    localparam int NB1    = 32;
    localparam int KQ     = 3329;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with D=12 ----------------
    logic       start12    = 1'b0;
    logic       abort12    = 1'b0;
    logic [1:0] bank_sel12 = 2'd0;
    logic       in_valid12 = 1'b0;
    logic [7:0] in_data12  = 8'h00;
    logic       in_ready12, busy12, done12, rerr12;

    poly_unpack_writer_if #(.BANK_W(2), .ADDR_W(8), .W(16)) pu12 ();

    poly_unpack_writer #(.D(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort12),
        .bank_sel(bank_sel12), .in_valid(in_valid12), .in_data(in_data12),
        .in_ready(in_ready12), .pu(pu12), .busy(busy12), .done(done12),
        .range_err(rerr12)
    );

    // ---------------- DUT with D=1 ----------------
    logic       start1    = 1'b0;
    logic       abort1    = 1'b0;
    logic [1:0] bank_sel1 = 2'd0;
    logic       in_valid1 = 1'b0;
    logic [7:0] in_data1  = 8'h00;
    logic       in_ready1, busy1, done1, rerr1;

    poly_unpack_writer_if #(.BANK_W(2), .ADDR_W(8), .W(16)) pu1 ();

    poly_unpack_writer #(.D(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .bank_sel(bank_sel1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .pu(pu1), .busy(busy1), .done(done1),
        .range_err(rerr1)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  bytes12 [0:383];
    logic [7:0]  bytes1  [0:383];
    logic [15:0] exp12   [0:255];
    logic [15:0] exp1    [0:255];
    bit          any_ge12;

    logic [7:0] q12[$];
    logic [7:0] q1[$];

    int unsigned valid_pct = 100;
    int unsigned stall_pct = 0;
    bit          stall_man = 1'b0;
    bit          stall_val = 1'b0;

    int cyc = 0;
    int wr12 = 0, bytes_acc12 = 0, last_wr12 = 0, done_cnt12 = 0, stall_cyc12 = 0;
    int exp_bank12 = 0;
    bit aborted12 = 1'b0;
    bit prev_st12 = 1'b0;
    int prev_addr12 = 0, prev_data12 = 0, prev_bank12 = 0;

    int wr1 = 0, bytes_acc1 = 0, last_wr1 = 0, done_cnt1 = 0;
    int exp_bank1 = 0;

    task automatic chk_eq(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Coefficient idx of a ByteDecode_d stream: d consecutive bits, LSB first.
    function automatic int model_raw(input logic [7:0] arr [0:383], input int d, input int idx);
        int raw = 0;
        for (int b = 0; b < d; b++) begin
            int p = idx * d + b;
            if (arr[p / 8][p % 8]) raw += (1 << b);
        end
        return raw;
    endfunction

    task automatic build_exp12();
        any_ge12 = 1'b0;
        for (int i = 0; i < NCOEF; i++) begin
            int raw = model_raw(bytes12, 12, i);
            if (raw >= KQ) begin
                any_ge12 = 1'b1;
                raw -= KQ;
            end
            exp12[i] = 16'(raw);
        end
    endtask

    task automatic build_exp1();
        for (int i = 0; i < NCOEF; i++) exp1[i] = 16'(model_raw(bytes1, 1, i));
    endtask

    task automatic rand_bytes12();
        for (int i = 0; i < NB12; i++) bytes12[i] = 8'($urandom_range(255));
    endtask

    // ---------------- driver: byte sources and stall ----------------
    initial begin
        bit hs12, hs1;
        forever begin
            @(negedge clk);
            hs12 = in_valid12 && in_ready12;
            hs1  = in_valid1 && in_ready1;
            @(posedge clk);
            #2;
            if (hs12 && q12.size() > 0) void'(q12.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            in_valid12 = (q12.size() > 0) && ($urandom_range(99) < valid_pct);
            in_data12  = (q12.size() > 0) ? q12[0] : 8'h00;
            pu12.pu_stall = stall_man ? stall_val : ($urandom_range(99) < stall_pct);
            in_valid1  = (q1.size() > 0);
            in_data1   = (q1.size() > 0) ? q1[0] : 8'h00;
            pu1.pu_stall = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_st12 = 1'b0;
        end else begin
            if (in_ready12 || pu12.pu_req)
                chk_eq("exclusive12", int'(in_ready12 && pu12.pu_req), 0);
            if (prev_st12) begin
                chk_eq("stall_hold_req", int'(pu12.pu_req), 1);
                chk_eq("stall_hold_addr", int'(pu12.pu_addr), prev_addr12);
                chk_eq("stall_hold_data", int'(pu12.pu_wdata), prev_data12);
                chk_eq("stall_hold_bank", int'(pu12.pu_bank), prev_bank12);
            end
            if (pu12.pu_req && pu12.pu_stall) stall_cyc12++;
            prev_st12   = pu12.pu_req && pu12.pu_stall;
            prev_addr12 = int'(pu12.pu_addr);
            prev_data12 = int'(pu12.pu_wdata);
            prev_bank12 = int'(pu12.pu_bank);
            if (pu12.pu_req && !pu12.pu_stall) begin
                chk_eq("we12", int'(pu12.pu_we), 1);
                chk_eq("addr12", int'(pu12.pu_addr), wr12);
                chk_eq("bank12", int'(pu12.pu_bank), exp_bank12);
                if (wr12 < NCOEF) chk_eq("data12", int'(pu12.pu_wdata), int'(exp12[wr12]));
                wr12++;
                last_wr12 = cyc;
            end
            if (in_valid12 && in_ready12) begin
                chk_eq("byte_limit12", int'(bytes_acc12 < NB12), 1);
                bytes_acc12++;
            end
            if (done12) begin
                chk_eq("done_not_aborted12", int'(aborted12), 0);
                chk_eq("done_writes12", wr12, NCOEF);
                chk_eq("done_latency12", cyc - last_wr12, 1);
                done_cnt12++;
            end

            if (in_ready1 || pu1.pu_req)
                chk_eq("exclusive1", int'(in_ready1 && pu1.pu_req), 0);
            if (pu1.pu_req && !pu1.pu_stall) begin
                chk_eq("addr1", int'(pu1.pu_addr), wr1);
                chk_eq("bank1", int'(pu1.pu_bank), exp_bank1);
                if (wr1 < NCOEF) chk_eq("data1", int'(pu1.pu_wdata), int'(exp1[wr1]));
                wr1++;
                last_wr1 = cyc;
            end
            if (in_valid1 && in_ready1) begin
                // a byte is fetched only once all 8 bits of the previous one are written
                chk_eq("fetch_point1", wr1, 8 * bytes_acc1);
                bytes_acc1++;
            end
            if (done1) begin
                chk_eq("done_writes1", wr1, NCOEF);
                chk_eq("done_latency1", cyc - last_wr1, 1);
                done_cnt1++;
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run12(input int bank);
        wr12 = 0; bytes_acc12 = 0; done_cnt12 = 0; stall_cyc12 = 0;
        aborted12 = 1'b0; exp_bank12 = bank;
        bank_sel12 = 2'(bank);
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
    endtask

    task automatic abort_run12();
        aborted12 = 1'b1;
        abort12 = 1'b1;
        tick();
        abort12 = 1'b0;
    endtask

    task automatic wait_wr12(input int n, input int budget);
        int k = 0;
        while (wr12 < n && k < budget) begin tick(); k++; end
        chk_eq("wait_writes12", int'(wr12 >= n), 1);
    endtask

    task automatic queue12(input int count);
        q12.delete();
        for (int i = 0; i < count; i++) q12.push_back(bytes12[i]);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int k;

        // reset state
        tick(); tick();
        chk_eq("rst_busy", int'(busy12), 0);
        chk_eq("rst_done", int'(done12), 0);
        chk_eq("rst_in_ready", int'(in_ready12), 0);
        chk_eq("rst_pu_req", int'(pu12.pu_req), 0);
        chk_eq("rst_range_err", int'(rerr12), 0);
        rst_n = 1'b1;
        tick(); tick();

        // T1: 01 23 45 into bank 2
        rand_bytes12();
        bytes12[0] = 8'h01; bytes12[1] = 8'h23; bytes12[2] = 8'h45;
        build_exp12();
        chk_eq("model_pin_0x301", int'(exp12[0]), 16'h301);
        chk_eq("model_pin_0x452", int'(exp12[1]), 16'h452);
        valid_pct = 100; stall_pct = 0;
        queue12(3);
        start_run12(2);
        chk_eq("busy_after_start", int'(busy12), 1);
        wait_wr12(2, 50);
        chk_eq("t1_range_err", int'(rerr12), 0);
        abort_run12();
        chk_eq("t1_busy_after_abort", int'(busy12), 0);
        tick(); tick();

        // T2: FF FF FF -> 766, 766 and sticky range_err
        bytes12[0] = 8'hFF; bytes12[1] = 8'hFF; bytes12[2] = 8'hFF;
        build_exp12();
        chk_eq("model_pin_766a", int'(exp12[0]), 766);
        chk_eq("model_pin_766b", int'(exp12[1]), 766);
        queue12(3);
        start_run12(1);
        wait_wr12(2, 50);
        chk_eq("t2_range_err", int'(rerr12), 1);
        abort_run12();
        tick(); tick();
        chk_eq("t2_range_err_sticky", int'(rerr12), 1);

        // T3: first write stalled for 3 cycles
        rand_bytes12();
        build_exp12();
        queue12(8);
        stall_man = 1'b1; stall_val = 1'b1;
        start_run12(3);
        chk_eq("t3_range_err_cleared", int'(rerr12), 0);
        k = 0;
        while (!pu12.pu_req && k < 50) begin tick(); k++; end
        chk_eq("t3_req_seen", int'(pu12.pu_req), 1);
        for (int c = 0; c < 3; c++) begin
            chk_eq("t3_stall_req", int'(pu12.pu_req), 1);
            chk_eq("t3_stall_addr", int'(pu12.pu_addr), 0);
            chk_eq("t3_stall_in_ready", int'(in_ready12), 0);
            if (c < 2) tick();
        end
        tick();
        stall_val = 1'b0;
        wait_wr12(1, 20);
        chk_eq("t3_stall_cycles", stall_cyc12, 3);
        chk_eq("t3_single_write", wr12, 1);
        stall_man = 1'b0;
        abort_run12();
        q12.delete();
        tick(); tick();

        // T4: abort after 10 writes, then full random run into bank 0
        rand_bytes12();
        build_exp12();
        valid_pct = 70; stall_pct = 25;
        queue12(NB12);
        start_run12(1);
        wait_wr12(10, 500);
        abort_run12();
        chk_eq("t4_busy_after_abort", int'(busy12), 0);
        q12.delete();
        for (int i = 0; i < 6; i++) tick();
        chk_eq("t4_no_done_aborted", done_cnt12, 0);

        rand_bytes12();
        build_exp12();
        queue12(NB12);
        q12.push_back(8'h5A);
        start_run12(0);
        k = 0;
        while (done_cnt12 == 0 && k < 6000) begin tick(); k++; end
        chk_eq("t4_done_seen", done_cnt12, 1);
        chk_eq("t4_writes", wr12, NCOEF);
        chk_eq("t4_bytes", bytes_acc12, NB12);
        chk_eq("t4_range_err", int'(rerr12), int'(any_ge12));
        chk_eq("t4_busy_end", int'(busy12), 0);
        for (int i = 0; i < 20; i++) tick();
        chk_eq("t4_done_once", done_cnt12, 1);
        chk_eq("t4_extra_byte_left", q12.size(), 1);
        q12.delete();
        valid_pct = 100; stall_pct = 0;

        // T5: D=1 build, first byte 0xA5
        for (int i = 0; i < NB12; i++) bytes1[i] = 8'($urandom_range(255));
        bytes1[0] = 8'hA5;
        build_exp1();
        begin
            logic [7:0] pin_bits;
            pin_bits = 8'b1010_0101;
            for (int i = 0; i < 8; i++) chk_eq("model_pin_d1", int'(exp1[i]), int'(pin_bits[i]));
        end
        q1.delete();
        for (int i = 0; i < NB1; i++) q1.push_back(bytes1[i]);
        q1.push_back(8'hFF);
        wr1 = 0; bytes_acc1 = 0; done_cnt1 = 0; exp_bank1 = 3;
        bank_sel1 = 2'd3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 0;
        while (done_cnt1 == 0 && k < 2000) begin tick(); k++; end
        chk_eq("t5_done_seen", done_cnt1, 1);
        chk_eq("t5_writes", wr1, NCOEF);
        chk_eq("t5_bytes", bytes_acc1, NB1);
        chk_eq("t5_range_err", int'(rerr1), 0);
        q1.delete();

        // T6: asynchronous reset mid-run
        rand_bytes12();
        build_exp12();
        queue12(NB12);
        start_run12(3);
        wait_wr12(20, 500);
        aborted12 = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_busy", int'(busy12), 0);
        chk_eq("t6_in_ready", int'(in_ready12), 0);
        chk_eq("t6_pu_req", int'(pu12.pu_req), 0);
        chk_eq("t6_pu_we", int'(pu12.pu_we), 0);
        chk_eq("t6_pu_addr", int'(pu12.pu_addr), 0);
        chk_eq("t6_pu_wdata", int'(pu12.pu_wdata), 0);
        chk_eq("t6_pu_bank", int'(pu12.pu_bank), 0);
        chk_eq("t6_done", int'(done12), 0);
        chk_eq("t6_range_err", int'(rerr12), 0);
        q12.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_eq("t6_idle_after_reset", int'(busy12), 0);
        chk_eq("t6_no_done", done_cnt12, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
